// File: rtl/hazard_pkg.sv
// Shared types and sizing for the pipeline hazard controller.
package hazard_pkg;

   localparam int unsigned REG_ADDR_W       = 4;
   localparam int unsigned DATA_W           = 16;
   localparam int unsigned LOAD_BUBBLES_MAX = 7;
   localparam int unsigned CNT_W            = 3;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_BUBBLE,
      ST_MEM_WAIT,
      ST_HALT
   } state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-detection inputs from ID/EX/MEM and the stall/flush controls returned to the pipeline.
interface hazard_ctrl_if;
   import hazard_pkg::*;

   logic [REG_ADDR_W-1:0] p0_addr_ID;
   logic [REG_ADDR_W-1:0] p1_addr_ID;
   logic                  p0_used_ID;
   logic                  p1_used_ID;
   logic [REG_ADDR_W-1:0] dst_addr_EX;
   logic                  we_ex;
   logic                  ld_ex;
   logic                  redirect_ex;
   logic                  halt_ex;
   logic                  dmem_req;
   logic                  dmem_rdy;
   logic                  stall_if;
   logic                  stall_id;
   logic                  stall_ex;
   logic                  stall_mem;
   logic                  flush_id;
   logic                  flush_ex;
   logic                  kill_wb;
   logic                  halted;

   modport master (
      output p0_addr_ID, p1_addr_ID, p0_used_ID, p1_used_ID, dst_addr_EX,
             we_ex, ld_ex, redirect_ex, halt_ex, dmem_req, dmem_rdy,
      input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
             kill_wb, halted
   );

   modport slave (
      input  p0_addr_ID, p1_addr_ID, p0_used_ID, p1_used_ID, dst_addr_EX,
             we_ex, ld_ex, redirect_ex, halt_ex, dmem_req, dmem_rdy,
      output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
             kill_wb, halted
   );

endinterface

// File: rtl/hazard_match.sv
// Source-vs-destination register compare, qualified by source use and destination write.
module hazard_match
   import hazard_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] src_addr,
   input  logic                  src_used,
   input  logic [REG_ADDR_W-1:0] dst_addr,
   input  logic                  dst_we,
   output logic                  hit
);

   always_comb begin
      hit = src_used & dst_we & (src_addr == dst_addr);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, dmem wait stalls, redirect flushes, HALT drain.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned LOAD_BUBBLES = 1,
   parameter int unsigned PERF_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   hazard_ctrl_if.slave      bus
`ifdef HAZARD_PERF_EN
   ,
   output logic [PERF_W-1:0] stall_cycles,
   output logic [PERF_W-1:0] flush_events
`endif
);

   if (LOAD_BUBBLES < 1 || LOAD_BUBBLES > LOAD_BUBBLES_MAX || PERF_W < 1) begin : g_bad_cfg
      $error("hazard_ctrl: LOAD_BUBBLES must be 1..7 and PERF_W >= 1");
   end

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hit_p0, hit_p1, luh, mw, redirect_flush;

   hazard_match u_match_p0 (
      .src_addr (bus.p0_addr_ID),
      .src_used (bus.p0_used_ID),
      .dst_addr (bus.dst_addr_EX),
      .dst_we   (bus.we_ex),
      .hit      (hit_p0)
   );

   hazard_match u_match_p1 (
      .src_addr (bus.p1_addr_ID),
      .src_used (bus.p1_used_ID),
      .dst_addr (bus.dst_addr_EX),
      .dst_we   (bus.we_ex),
      .hit      (hit_p1)
   );

   // While waiting, the access is frozen in MEM, so only dmem_rdy ends the wait.
   always_comb begin
      luh = bus.ld_ex & (hit_p0 | hit_p1);
      mw  = (state_q == ST_MEM_WAIT) ? ~bus.dmem_rdy : (bus.dmem_req & ~bus.dmem_rdy);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RUN, ST_MEM_WAIT: begin
            if (mw) begin
               state_d = ST_MEM_WAIT;
            end else if (bus.redirect_ex) begin
               state_d = ST_RUN;
            end else if (luh) begin
               state_d = ST_RUN;
               if (LOAD_BUBBLES > 1) begin
                  cnt_d   = CNT_W'(LOAD_BUBBLES - 1);
                  state_d = ST_BUBBLE;
               end
            end else if (bus.halt_ex) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_BUBBLE: begin
            if (!mw) begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = ST_RUN;
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      bus.stall_if   = 1'b0;
      bus.stall_id   = 1'b0;
      bus.stall_ex   = 1'b0;
      bus.stall_mem  = 1'b0;
      bus.flush_id   = 1'b0;
      bus.flush_ex   = 1'b0;
      bus.kill_wb    = 1'b0;
      bus.halted     = 1'b0;
      redirect_flush = 1'b0;
      if (!rst_n) begin
         bus.flush_id = 1'b1;
         bus.flush_ex = 1'b1;
         bus.kill_wb  = 1'b1;
      end else if (mw) begin
         bus.stall_if  = 1'b1;
         bus.stall_id  = 1'b1;
         bus.stall_ex  = 1'b1;
         bus.stall_mem = 1'b1;
         bus.kill_wb   = 1'b1;
         bus.halted    = (state_q == ST_HALT);
      end else begin
         case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
               if (bus.redirect_ex) begin
                  bus.flush_id   = 1'b1;
                  bus.flush_ex   = 1'b1;
                  redirect_flush = 1'b1;
               end else if (luh) begin
                  bus.stall_if = 1'b1;
                  bus.stall_id = 1'b1;
                  bus.flush_ex = 1'b1;
               end else if (bus.halt_ex) begin
                  bus.stall_if = 1'b1;
                  bus.flush_id = 1'b1;
               end
            end
            ST_BUBBLE: begin
               bus.stall_if = 1'b1;
               bus.stall_id = 1'b1;
               bus.flush_ex = 1'b1;
            end
            ST_HALT: begin
               bus.stall_if = 1'b1;
               bus.flush_id = 1'b1;
               bus.halted   = 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [PERF_W-1:0] flush_events_q, flush_events_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_events_d = flush_events_q;
      if (rst_n && bus.stall_if && stall_cycles_q != '1)
         stall_cycles_d = stall_cycles_q + PERF_W'(1);
      if (redirect_flush && flush_events_q != '1)
         flush_events_d = flush_events_q + PERF_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_events_q <= flush_events_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;
`endif

endmodule
